// File: rtl/psum_accum_writeback.sv
`default_nettype none
// ============================================================================
// Module   : psum_accum_writeback
// Purpose  : Psum BRAM write-back with read-modify-write accumulate, RAW
//            forwarding, configurable read latency and flush/done handshake.
//            Optional macro PSUM_SAT_EN: saturating accumulate + sat_flag.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module psum_accum_writeback #(
  parameter int ARRAY_DIM  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           in_clear,
  input  logic [ADDR_WIDTH-1:0]          in_addr,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0] in_data,
  input  logic                           flush,
  output logic                           mem_ren,
  output logic [ADDR_WIDTH-1:0]          mem_raddr,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0] mem_rdata,
  output logic                           mem_wen,
  output logic [ADDR_WIDTH-1:0]          mem_waddr,
  output logic [ARRAY_DIM*ACC_WIDTH-1:0] mem_wdata,
  output logic                           busy,
`ifdef PSUM_SAT_EN
  output logic                           sat_flag,
`endif
  output logic                           flush_done
);

  localparam int c_DATA_W = ARRAY_DIM * ACC_WIDTH;
  localparam int c_HIST   = RD_LAT + 1;
  localparam int c_MSB    = ACC_WIDTH - 1;

  // Issue stage
  logic [ADDR_WIDTH-1:0] r_raddr;

  assign mem_ren   = in_valid & ~in_clear;
  assign mem_raddr = in_valid ? in_addr : r_raddr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_raddr <= '0;
    end else if (in_valid) begin
      r_raddr <= in_addr;
    end
  end

  // Delay stages aligning the beat with its BRAM read data
  logic [RD_LAT-1:0]     r_d_valid;
  logic [RD_LAT-1:0]     r_d_clear;
  logic [ADDR_WIDTH-1:0] r_d_addr [RD_LAT];
  logic [c_DATA_W-1:0]   r_d_data [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d_valid <= '0;
      r_d_clear <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_d_addr[i] <= '0;
        r_d_data[i] <= '0;
      end
    end else begin
      r_d_valid[0] <= in_valid;
      r_d_clear[0] <= in_clear;
      r_d_addr[0]  <= in_addr;
      r_d_data[0]  <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        r_d_valid[i] <= r_d_valid[i-1];
        r_d_clear[i] <= r_d_clear[i-1];
        r_d_addr[i]  <= r_d_addr[i-1];
        r_d_data[i]  <= r_d_data[i-1];
      end
    end
  end

  logic                  w_a_valid;
  logic                  w_a_clear;
  logic [ADDR_WIDTH-1:0] w_a_addr;
  logic [c_DATA_W-1:0]   w_a_data;

  assign w_a_valid = r_d_valid[RD_LAT-1];
  assign w_a_clear = r_d_clear[RD_LAT-1];
  assign w_a_addr  = r_d_addr[RD_LAT-1];
  assign w_a_data  = r_d_data[RD_LAT-1];

  // Write stage and history of recently written beats
  logic                  r_wr_valid;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [c_DATA_W-1:0]   r_wr_data;
  logic [c_HIST-1:0]     r_h_valid;
  logic [ADDR_WIDTH-1:0] r_h_addr [c_HIST];
  logic [c_DATA_W-1:0]   r_h_data [c_HIST];

  // Oldest match first so the youngest write overrides it
  logic [c_DATA_W-1:0] w_base;

  always_comb begin
    w_base = mem_rdata;
    for (int i = c_HIST - 1; i >= 0; i--) begin
      if (r_h_valid[i] && (r_h_addr[i] == w_a_addr)) begin
        w_base = r_h_data[i];
      end
    end
    if (r_wr_valid && (r_wr_addr == w_a_addr)) begin
      w_base = r_wr_data;
    end
  end

  // Add stage: per-lane accumulate
  logic [c_DATA_W-1:0]  w_sum;
  logic [ACC_WIDTH-1:0] w_op_a;
  logic [ACC_WIDTH-1:0] w_op_b;
  logic [ACC_WIDTH-1:0] w_lane;
`ifdef PSUM_SAT_EN
  logic                 w_clip;
`endif

  always_comb begin
    w_sum  = '0;
    w_op_a = '0;
    w_op_b = '0;
    w_lane = '0;
`ifdef PSUM_SAT_EN
    w_clip = 1'b0;
`endif
    for (int l = 0; l < ARRAY_DIM; l++) begin
      w_op_a = w_base[l*ACC_WIDTH +: ACC_WIDTH];
      w_op_b = w_a_data[l*ACC_WIDTH +: ACC_WIDTH];
      w_lane = w_op_a + w_op_b;
`ifdef PSUM_SAT_EN
      // Overflow only when both operands share a sign the sum does not
      if ((w_op_a[c_MSB] == w_op_b[c_MSB]) && (w_lane[c_MSB] != w_op_a[c_MSB])) begin
        w_clip = 1'b1;
        w_lane = w_op_a[c_MSB] ? {1'b1, {c_MSB{1'b0}}} : {1'b0, {c_MSB{1'b1}}};
      end
`endif
      w_sum[l*ACC_WIDTH +: ACC_WIDTH] = w_lane;
    end
  end

  logic [c_DATA_W-1:0] w_result;
  assign w_result = w_a_clear ? w_a_data : w_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_h_valid  <= '0;
      for (int i = 0; i < c_HIST; i++) begin
        r_h_addr[i] <= '0;
        r_h_data[i] <= '0;
      end
    end else begin
      r_wr_valid <= w_a_valid;
      if (w_a_valid) begin
        r_wr_addr <= w_a_addr;
        r_wr_data <= w_result;
      end
      r_h_valid[0] <= r_wr_valid;
      r_h_addr[0]  <= r_wr_addr;
      r_h_data[0]  <= r_wr_data;
      for (int i = 1; i < c_HIST; i++) begin
        r_h_valid[i] <= r_h_valid[i-1];
        r_h_addr[i]  <= r_h_addr[i-1];
        r_h_data[i]  <= r_h_data[i-1];
      end
    end
  end

  assign mem_wen   = r_wr_valid;
  assign mem_waddr = r_wr_addr;
  assign mem_wdata = r_wr_data;

  // Flush handshake
  logic r_flush_pend;
  logic w_any_valid;

  assign w_any_valid = (|r_d_valid) | r_wr_valid;
  assign flush_done  = r_flush_pend & ~w_any_valid & ~in_valid;
  assign busy        = w_any_valid | r_flush_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
    end else if (flush_done) begin
      r_flush_pend <= 1'b0;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end
  end

`ifdef PSUM_SAT_EN
  logic r_sat_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat_flag <= 1'b0;
    end else if (flush_done) begin
      r_sat_flag <= 1'b0;
    end else if (w_a_valid && !w_a_clear && w_clip) begin
      r_sat_flag <= 1'b1;
    end
  end

  assign sat_flag = r_sat_flag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_psum_accum_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_accum_writeback
// Purpose  : Directed self-checking bench; one RD_LAT=1 and one RD_LAT=3 DUT,
//            each attached to a read-first BRAM model.
// Revision : 1.0
// ============================================================================
module tb_psum_accum_writeback;

  localparam int DW = 16 * 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic          a_valid, a_clear, a_flush, a_ren, a_wen, a_busy, a_done;
  logic [9:0]    a_addr, a_raddr, a_waddr;
  logic [DW-1:0] a_data, a_rdata, a_wdata;
  logic          b_valid, b_clear, b_flush, b_ren, b_wen, b_busy, b_done;
  logic [9:0]    b_addr, b_raddr, b_waddr;
  logic [DW-1:0] b_data, b_rdata, b_wdata;
`ifdef PSUM_SAT_EN
  logic          a_sat, b_sat;
`endif

  logic          pl_en;
  logic [9:0]    pl_addr;
  logic [DW-1:0] pl_data;

  psum_accum_writeback #(.ARRAY_DIM(16), .ACC_WIDTH(32), .ADDR_WIDTH(10), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_clear(a_clear), .in_addr(a_addr),
    .in_data(a_data), .flush(a_flush), .mem_ren(a_ren), .mem_raddr(a_raddr),
    .mem_rdata(a_rdata), .mem_wen(a_wen), .mem_waddr(a_waddr), .mem_wdata(a_wdata),
    .busy(a_busy),
`ifdef PSUM_SAT_EN
    .sat_flag(a_sat),
`endif
    .flush_done(a_done)
  );

  psum_accum_writeback #(.ARRAY_DIM(16), .ACC_WIDTH(32), .ADDR_WIDTH(10), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_clear(b_clear), .in_addr(b_addr),
    .in_data(b_data), .flush(b_flush), .mem_ren(b_ren), .mem_raddr(b_raddr),
    .mem_rdata(b_rdata), .mem_wen(b_wen), .mem_waddr(b_waddr), .mem_wdata(b_wdata),
    .busy(b_busy),
`ifdef PSUM_SAT_EN
    .sat_flag(b_sat),
`endif
    .flush_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM models
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] a_rp;
  logic [DW-1:0] b_rp0, b_rp1, b_rp2;

  always_ff @(posedge clk) begin
    if (a_ren) a_rp <= mem_a[a_raddr];
    if (a_wen) mem_a[a_waddr] <= a_wdata;
    if (b_ren) b_rp0 <= mem_b[b_raddr];
    b_rp1 <= b_rp0;
    b_rp2 <= b_rp1;
    if (b_wen) mem_b[b_waddr] <= b_wdata;
    if (pl_en) begin
      mem_a[pl_addr] <= pl_data;
      mem_b[pl_addr] <= pl_data;
    end
  end

  assign a_rdata = a_rp;
  assign b_rdata = b_rp2;

  function automatic logic [DW-1:0] rep(input logic [31:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] lane1(input logic [31:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[63:32] = v;
    return r;
  endfunction

  task automatic idle_all();
    a_valid = 0; a_clear = 0; a_flush = 0; a_addr = '0; a_data = '0;
    b_valid = 0; b_clear = 0; b_flush = 0; b_addr = '0; b_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] ad, input logic [DW-1:0] d);
    pl_en = 1; pl_addr = ad; pl_data = d;
    next_cycle();
    pl_en = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    total++; if (a_wen !== 1'b0) begin bad++; $display("FAIL reset_a_wen: got %b want 0", a_wen); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_a_done: got %b want 0", a_done); end
    total++; if (a_ren !== 1'b0) begin bad++; $display("FAIL reset_a_ren: got %b want 0", a_ren); end
    total++; if (a_raddr !== 10'd0) begin bad++; $display("FAIL reset_a_raddr: got %h want 0", a_raddr); end
    total++; if (a_wdata !== '0) begin bad++; $display("FAIL reset_a_wdata: got %h want 0", a_wdata); end
    total++; if (b_wen !== 1'b0) begin bad++; $display("FAIL reset_b_wen: got %b want 0", b_wen); end
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
`ifdef PSUM_SAT_EN
    total++; if (a_sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", a_sat); end
`endif
    next_cycle();
  endtask

  task automatic test_clear_write();
    for (int c = 0; c < 4; c++) begin
      a_valid = (c == 0); a_clear = 1; a_addr = 10'd5; a_data = rep(32'd7);
      @(negedge clk);
      if (c == 0) begin
        total++; if (a_ren !== 1'b0) begin bad++; $display("FAIL clear_ren: got %b want 0", a_ren); end
      end
      total++; if (a_wen !== (c == 2)) begin bad++; $display("FAIL clear_wen c=%0d: got %b want %b", c, a_wen, (c == 2)); end
      if (c == 2) begin
        total++; if (a_waddr !== 10'd5) begin bad++; $display("FAIL clear_waddr: got %0d want 5", a_waddr); end
        total++; if (a_wdata !== rep(32'd7)) begin bad++; $display("FAIL clear_wdata: got %h want %h", a_wdata, rep(32'd7)); end
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_accumulate();
    preload(10'd5, rep(32'd7));
    for (int c = 0; c < 4; c++) begin
      a_valid = (c == 0); a_clear = 0; a_addr = 10'd5; a_data = rep(32'd3);
      @(negedge clk);
      if (c == 0) begin
        total++; if (a_ren !== 1'b1) begin bad++; $display("FAIL acc_ren: got %b want 1", a_ren); end
        total++; if (a_raddr !== 10'd5) begin bad++; $display("FAIL acc_raddr: got %0d want 5", a_raddr); end
      end
      total++; if (a_wen !== (c == 2)) begin bad++; $display("FAIL acc_wen c=%0d: got %b want %b", c, a_wen, (c == 2)); end
      if (c == 2) begin
        total++; if (a_wdata !== rep(32'd10)) begin bad++; $display("FAIL acc_wdata: got %h want %h", a_wdata, rep(32'd10)); end
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_lanes();
    logic [DW-1:0] st, dat, exp_v;
    for (int i = 0; i < 16; i++) begin
      st[i*32 +: 32]    = 32'(i * 16);
      dat[i*32 +: 32]   = 32'(i) - 32'd3;
      exp_v[i*32 +: 32] = 32'(i * 17) - 32'd3;
    end
    preload(10'd30, st);
    for (int c = 0; c < 4; c++) begin
      a_valid = (c == 0); a_clear = 0; a_addr = (c == 0) ? 10'd30 : 10'd99; a_data = dat;
      @(negedge clk);
      if (c == 1) begin
        total++; if (a_raddr !== 10'd30) begin bad++; $display("FAIL lanes_raddr_hold: got %0d want 30", a_raddr); end
        total++; if (a_ren !== 1'b0) begin bad++; $display("FAIL lanes_ren_idle: got %b want 0", a_ren); end
      end
      if (c == 2) begin
        total++; if (a_wdata !== exp_v) begin bad++; $display("FAIL lanes_wdata: got %h want %h", a_wdata, exp_v); end
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_l;
    preload(10'd9, rep(32'd100));
    for (int c = 0; c < 6; c++) begin
      a_valid = (c < 3); a_clear = (c == 0); a_addr = 10'd9;
      a_data = (c == 0) ? rep(32'd1) : rep(32'd2);
      @(negedge clk);
      total++; if (a_wen !== (c >= 2 && c <= 4)) begin bad++; $display("FAIL b2b_wen c=%0d: got %b", c, a_wen); end
      if (c >= 2 && c <= 4) begin
        exp_l = (c == 2) ? 32'd1 : (c == 3) ? 32'd3 : 32'd5;
        total++; if (a_wdata !== rep(exp_l)) begin bad++; $display("FAIL b2b_wdata c=%0d: got %h want %h", c, a_wdata, rep(exp_l)); end
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_rdlat3();
    logic [9:0]  exp_a;
    logic [31:0] exp_l;
    preload(10'd1, '0);
    preload(10'd2, '0);
    for (int c = 0; c < 9; c++) begin
      b_valid = (c < 4); b_clear = 0; b_addr = (c % 2 == 0) ? 10'd1 : 10'd2; b_data = lane1(32'd1);
      @(negedge clk);
      if (c == 0) begin
        total++; if (b_ren !== 1'b1) begin bad++; $display("FAIL rl3_ren: got %b want 1", b_ren); end
      end
      total++; if (b_wen !== (c >= 4 && c <= 7)) begin bad++; $display("FAIL rl3_wen c=%0d: got %b", c, b_wen); end
      if (c >= 4 && c <= 7) begin
        exp_a = (c % 2 == 0) ? 10'd1 : 10'd2;
        exp_l = (c < 6) ? 32'd1 : 32'd2;
        total++; if (b_waddr !== exp_a) begin bad++; $display("FAIL rl3_waddr c=%0d: got %0d want %0d", c, b_waddr, exp_a); end
        total++; if (b_wdata !== lane1(exp_l)) begin bad++; $display("FAIL rl3_wdata c=%0d: got %h want %h", c, b_wdata, lane1(exp_l)); end
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_forward_depth();
    preload(10'd7, rep(32'd50));
    for (int c = 0; c < 10; c++) begin
      b_valid = (c == 0 || c == 4); b_clear = (c == 0); b_addr = 10'd7; b_data = rep(32'd1);
      @(negedge clk);
      total++; if (b_wen !== (c == 4 || c == 8)) begin bad++; $display("FAIL depth_wen c=%0d: got %b", c, b_wen); end
      if (c == 8) begin
        total++; if (b_wdata !== rep(32'd2)) begin bad++; $display("FAIL depth_wdata: got %h want %h", b_wdata, rep(32'd2)); end
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_flush();
    for (int c = 0; c < 8; c++) begin
      a_valid = (c < 4); a_clear = 1; a_addr = 10'(40 + c); a_data = rep(32'(c + 1)); a_flush = (c == 3);
      @(negedge clk);
      total++; if (a_wen !== (c >= 2 && c <= 5)) begin bad++; $display("FAIL flush_wen c=%0d: got %b", c, a_wen); end
      if (c >= 2 && c <= 5) begin
        total++; if (a_waddr !== 10'(38 + c)) begin bad++; $display("FAIL flush_waddr c=%0d: got %0d want %0d", c, a_waddr, 38 + c); end
      end
      total++; if (a_done !== (c == 6)) begin bad++; $display("FAIL flush_done c=%0d: got %b want %b", c, a_done, (c == 6)); end
      if (c == 5) begin
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL flush_busy_hi: got %b want 1", a_busy); end
      end
      if (c == 7) begin
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL flush_busy_lo: got %b want 0", a_busy); end
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_flush_empty();
    for (int c = 0; c < 3; c++) begin
      a_flush = (c == 0);
      @(negedge clk);
      total++; if (a_done !== (c == 1)) begin bad++; $display("FAIL fempty_done c=%0d: got %b want %b", c, a_done, (c == 1)); end
      total++; if (a_busy !== (c == 1)) begin bad++; $display("FAIL fempty_busy c=%0d: got %b want %b", c, a_busy, (c == 1)); end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_flush_delay();
    for (int c = 0; c < 6; c++) begin
      a_flush = (c == 0); a_valid = (c == 1); a_clear = 1; a_addr = 10'd44; a_data = rep(32'd9);
      @(negedge clk);
      total++; if (a_wen !== (c == 3)) begin bad++; $display("FAIL fdelay_wen c=%0d: got %b", c, a_wen); end
      total++; if (a_done !== (c == 4)) begin bad++; $display("FAIL fdelay_done c=%0d: got %b want %b", c, a_done, (c == 4)); end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin
      a_valid = (c < 2); a_clear = 1; a_addr = 10'(50 + c); a_data = rep(32'd4);
      a_flush = (c == 0); rst_n = (c != 1);
      @(negedge clk);
      if (c >= 2) begin
        total++; if (a_wen !== 1'b0) begin bad++; $display("FAIL rmid_wen c=%0d: got %b want 0", c, a_wen); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy c=%0d: got %b want 0", c, a_busy); end
      end
      next_cycle();
    end
    rst_n = 1;
    idle_all();
  endtask

  task automatic test_saturate();
    logic [31:0] exp0, exp1;
`ifdef PSUM_SAT_EN
    exp0 = 32'h7FFF_FFFF; exp1 = 32'h8000_0000;
`else
    exp0 = 32'h8000_0000; exp1 = 32'h7FFF_FFFF;
`endif
    preload(10'd60, rep(32'h7FFF_FFFF));
    preload(10'd61, rep(32'h8000_0000));
    for (int c = 0; c < 7; c++) begin
      a_valid = (c < 2); a_clear = 0; a_addr = (c == 0) ? 10'd60 : 10'd61;
      a_data = (c == 0) ? rep(32'd1) : rep(32'hFFFF_FFFF); a_flush = (c == 4);
      @(negedge clk);
      if (c == 2) begin
        total++; if (a_wdata !== rep(exp0)) begin bad++; $display("FAIL sat_pos: got %h want %h", a_wdata, rep(exp0)); end
      end
      if (c == 3) begin
        total++; if (a_wdata !== rep(exp1)) begin bad++; $display("FAIL sat_neg: got %h want %h", a_wdata, rep(exp1)); end
      end
      if (c == 5) begin
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL sat_done: got %b want 1", a_done); end
      end
`ifdef PSUM_SAT_EN
      total++;
      if (a_sat !== (c >= 2 && c <= 5)) begin bad++; $display("FAIL sat_flag c=%0d: got %b want %b", c, a_sat, (c >= 2 && c <= 5)); end
`endif
      next_cycle();
    end
    idle_all();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    rst_n = 0;
    idle_all();
    test_reset();
    test_clear_write();
    test_accumulate();
    test_lanes();
    test_back_to_back();
    test_rdlat3();
    test_forward_depth();
    test_flush();
    test_flush_empty();
    test_flush_delay();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
